tilegroup_issue_fifo: RTL and testbench

Buffers TileGroup descriptors from the upstream TileGroup producer and issues them one at a time to `consumer_dpm`. Issue is paced by the consumer's `ready_to_consume` status. The block owns the FIFO whose front drives the consumer's `consume_start`. It enforces a hold-off after each issue so one TileGroup is never counted twice by the consumer's registered ready.

---
 rtl/tilegroup_issue_fifo.sv | 134 +++++++++++++
 tb/tb_tilegroup_issue_fifo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tilegroup_issue_fifo.sv
// tilegroup_issue_fifo: queues TileGroup IDs from the producer and issues them one at a time
// to consumer_dpm, with a forced hold-off after each issue. Stats counters need `define TGIF_STATS_EN.
module tilegroup_issue_fifo #(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 16,
  parameter int HOLDOFF = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         prod_valid,
  input  logic [WIDTH-1:0]             prod_tg_id,
  output logic                         prod_ready,
  input  logic                         ready_to_consume,
  output logic                         consume_start,
  output logic [WIDTH-1:0]             front_tg_id,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [31:0]                  issued_count,
  output logic [$clog2(DEPTH+1)-1:0]   max_occupancy,
  output logic [31:0]                  starve_cycles
);

  // state | meaning
  // IDLE  | may issue the FIFO front when the consumer is ready
  // HOLD  | hold-off countdown after an issue; no issue allowed

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam int HW = $clog2(HOLDOFF+1);
  localparam logic [OW-1:0] FULL_OCC  = OW'(DEPTH);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [OW-1:0]    occ_q, occ_d;
  logic             push, pop;

  // No bypass: a full FIFO refuses the producer even if a pop happens this cycle.
  assign prod_ready = (occ_q != FULL_OCC) && !rst && !flush;
  assign push       = prod_valid && prod_ready;
  assign occupancy  = occ_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((occ_q != '0) && ready_to_consume) begin
            pop     = 1'b1;
            state_d = HOLD;
            hold_d  = HOLD_INIT;
          end
        end
        HOLD: begin
          if (hold_q == '0) state_d = IDLE;
          else              hold_d  = hold_q - HW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (flush)              occ_d = '0;
    else if (push && !pop)  occ_d = occ_q + OW'(1);
    else if (pop && !push)  occ_d = occ_q - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      occ_q         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      consume_start <= 1'b0;
      front_tg_id   <= '0;
      issued_count  <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      occ_q         <= occ_d;
      consume_start <= pop;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr       <= rd_ptr + AW'(1);
          front_tg_id  <= mem[rd_ptr];
          issued_count <= issued_count + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= prod_tg_id;
  end

`ifdef TGIF_STATS_EN
  logic [OW-1:0] max_occ_q;
  logic [31:0]   starve_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      max_occ_q <= '0;
      starve_q  <= '0;
    end else begin
      if (occ_d > max_occ_q) max_occ_q <= occ_d;
      if ((state_q == IDLE) && ready_to_consume && (occ_q == '0) && (starve_q != 32'hFFFF_FFFF))
        starve_q <= starve_q + 32'd1;
    end
  end

  assign max_occupancy = max_occ_q;
  assign starve_cycles = starve_q;
`else
  assign max_occupancy = '0;
  assign starve_cycles = '0;
`endif

endmodule

// File: tb/tb_tilegroup_issue_fifo.sv
// Self-checking bench for tilegroup_issue_fifo: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_tilegroup_issue_fifo;
  localparam int DEPTH   = 16;
  localparam int WIDTH   = 16;
  localparam int HOLDOFF = 2;
  localparam int OW      = $clog2(DEPTH+1);
`ifdef TGIF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, flush, prod_valid, ready_to_consume;
  logic [WIDTH-1:0] prod_tg_id;
  logic             prod_ready, consume_start;
  logic [WIDTH-1:0] front_tg_id;
  logic [OW-1:0]    occupancy, max_occupancy;
  logic [31:0]      issued_count, starve_cycles;

  tilegroup_issue_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rst(rst), .flush(flush), .prod_valid(prod_valid), .prod_tg_id(prod_tg_id),
    .prod_ready(prod_ready), .ready_to_consume(ready_to_consume), .consume_start(consume_start),
    .front_tg_id(front_tg_id), .occupancy(occupancy), .issued_count(issued_count),
    .max_occupancy(max_occupancy), .starve_cycles(starve_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue plus the edge number of the last issue.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_front;
  logic             m_cs;
  logic [31:0]      m_issued, m_starve;
  int               m_maxocc;
  longint           edge_no, last_issue;

  task automatic model_reset();
    mq.delete();
    m_front = '0; m_cs = 1'b0; m_issued = '0; m_starve = '0; m_maxocc = 0;
    last_issue = -1000;
  endtask

  task automatic model_edge();
    bit idle, do_pop, do_push;
    if (rst) begin
      model_reset();
    end else begin
      idle    = (edge_no - last_issue) >= HOLDOFF + 2;
      do_pop  = idle && (mq.size() > 0) && ready_to_consume && !flush;
      do_push = prod_valid && (mq.size() != DEPTH) && !flush;
      if (STATS && idle && ready_to_consume && (mq.size() == 0) && (m_starve != 32'hFFFF_FFFF))
        m_starve++;
      m_cs = 1'b0;
      if (flush) begin
        mq.delete();
        last_issue = -1000;
      end else begin
        if (do_pop) begin
          m_front = mq.pop_front();
          m_cs = 1'b1;
          m_issued++;
          last_issue = edge_no;
        end
        if (do_push) mq.push_back(prod_tg_id);
      end
      if (STATS && (mq.size() > m_maxocc)) m_maxocc = mq.size();
    end
    edge_no++;
  endtask

  logic last_ready;

  task automatic drive(input logic r, input logic f, input logic pv, input logic [WIDTH-1:0] id,
                       input logic rtc);
    rst = r; flush = f; prod_valid = pv; prod_tg_id = id; ready_to_consume = rtc;
    #1;
    last_ready = prod_ready;
    check("model_prod_ready", prod_ready, !r && !f && (mq.size() != DEPTH));
  endtask

  task automatic clock_and_check();
    @(posedge clk);
    model_edge();
    #1;
    check("model_consume_start", consume_start, m_cs);
    check("model_front_tg_id", front_tg_id, m_front);
    check("model_occupancy", occupancy, mq.size());
    check("model_issued_count", issued_count, m_issued);
    check("model_max_occupancy", max_occupancy, m_maxocc);
    check("model_starve_cycles", starve_cycles, m_starve);
  endtask

  task automatic cycle(input logic r, input logic f, input logic pv, input logic [WIDTH-1:0] id,
                       input logic rtc);
    drive(r, f, pv, id, rtc);
    clock_and_check();
  endtask

  typedef struct {
    logic r, f, pv;
    logic [WIDTH-1:0] id;
    logic rtc;
    logic exp_ready, exp_cs;
    logic [WIDTH-1:0] exp_front;
    logic [OW-1:0] exp_occ;
  } vec_t;

  vec_t vt[12];

  initial begin
    int pulses;
    logic [31:0] saved_issued;
    edge_no = 0;
    model_reset();
    rst = 1'b1; flush = 1'b0; prod_valid = 1'b0; prod_tg_id = '0; ready_to_consume = 1'b0;

    // Reset, then IDs 1..3 back to back with the consumer ready: pulses 4 edges apart.
    vt[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h0000, 5'd1};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b1, 16'h0001, 5'd1};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b1, 1'b0, 16'h0001, 5'd2};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0001, 5'd2};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0001, 5'd2};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0002, 5'd1};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0002, 5'd1};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0002, 5'd1};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0002, 5'd1};
    vt[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0003, 5'd0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0003, 5'd0};

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].r, vt[i].f, vt[i].pv, vt[i].id, vt[i].rtc);
      check($sformatf("vec%0d_prod_ready", i), last_ready, vt[i].exp_ready);
      clock_and_check();
      check($sformatf("vec%0d_consume_start", i), consume_start, vt[i].exp_cs);
      check($sformatf("vec%0d_front_tg_id", i), front_tg_id, vt[i].exp_front);
      check($sformatf("vec%0d_occupancy", i), occupancy, vt[i].exp_occ);
    end
    check("vec_issued_count", issued_count, 32'd3);

    // Fill to full with the consumer stalled; a 17th offer is refused.
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, WIDTH'(16'h0100 + i), 1'b0);
    check("full_occupancy", occupancy, DEPTH);
    check("full_prod_ready", prod_ready, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 16'h01FF, 1'b0);
    check("full_17th_refused", occupancy, DEPTH);
    check("full_max_occupancy", max_occupancy, STATS ? DEPTH : 0);

    // Raise the consumer ready: no push on the issue edge, push accepted right after.
    cycle(1'b0, 1'b0, 1'b1, 16'h0200, 1'b1);
    check("full_ready_at_issue", last_ready, 1'b0);
    check("full_first_front", front_tg_id, 16'h0100);
    check("full_occ_after_issue", occupancy, DEPTH - 1);
    cycle(1'b0, 1'b0, 1'b1, 16'h0200, 1'b1);
    check("full_push_after_issue", occupancy, DEPTH);
    pulses = 1;
    for (int k = 0; k < 16 * (HOLDOFF + 2); k++) begin
      cycle(1'b0, 1'b0, 1'b1, WIDTH'(16'h0300 + k), 1'b1);
      if (consume_start) pulses++;
    end
    check("full_issue_count", pulses, 17);

    // Starved consumer on an empty FIFO.
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
      if (consume_start) pulses++;
    end
    check("starve_no_pulse", pulses, 0);
    check("starve_cycles_10", starve_cycles, STATS ? 10 : 0);

    // Flush during HOLD with 5 entries queued, push in the flush cycle dropped.
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, WIDTH'(16'h0A00 + i), 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("flush_pre_issue", consume_start, 1'b1);
    check("flush_pre_occ", occupancy, 5);
    saved_issued = issued_count;
    cycle(1'b0, 1'b1, 1'b1, 16'hDEAD, 1'b1);
    check("flush_ready_low", last_ready, 1'b0);
    check("flush_occupancy", occupancy, 0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
      if (consume_start) pulses++;
    end
    check("flush_no_pulse", pulses, 0);
    check("flush_issued_kept", issued_count, saved_issued);

    // Reset during the consume_start cycle.
    cycle(1'b0, 1'b0, 1'b1, 16'h0055, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("rst_pre_pulse", consume_start, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("rst_cs", consume_start, 1'b0);
    check("rst_front", front_tg_id, 0);
    check("rst_occ", occupancy, 0);
    check("rst_issued", issued_count, 0);
    check("rst_maxocc", max_occupancy, 0);
    check("rst_starve", starve_cycles, 0);
    cycle(1'b0, 1'b0, 1'b1, 16'h0077, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("rst_idle_issue", consume_start, 1'b1);
    check("rst_idle_front", front_tg_id, 16'h0077);

    // Randomized traffic with phases biased toward full and toward empty.
    for (int k = 0; k < 3000; k++) begin
      int phase;
      logic r, f, pv, rtc;
      phase = (k / 200) % 3;
      r   = ($urandom_range(0, 399) == 0);
      f   = ($urandom_range(0, 79) == 0);
      pv  = (phase == 0) ? ($urandom_range(0, 9) < 8) :
            (phase == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 1) == 1);
      rtc = (phase == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
      cycle(r, f, pv, WIDTH'($urandom), rtc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
